// File: rtl/wave_pkg.sv
// Shared widths and state encoding for the Wave MAC output accumulator.
package wave_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int PSUM_WIDTH   = DATA_WIDTH + 11;
  localparam int ACC_WIDTH    = DATA_WIDTH + 16;
  localparam int RESULT_WIDTH = 3 * DATA_WIDTH;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_t;

endpackage

// File: rtl/sat_add.sv
// Signed add of two differently sized operands into OUT_W bits, either wrapping
// or clamping to the signed range of OUT_W (SAT=1), with a clamp flag.
module sat_add #(
  parameter int A_W   = 24,
  parameter int B_W   = 19,
  parameter int OUT_W = 24,
  parameter bit SAT   = 1'b0
) (
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [OUT_W-1:0] sum,
  output logic                    ovf
);

  localparam int SUM_W = ((A_W > B_W) ? A_W : B_W) + 1;
  localparam int EXT_W = (SUM_W > OUT_W) ? SUM_W : OUT_W;

  logic signed [EXT_W-1:0] a_ext_s;
  logic signed [EXT_W-1:0] b_ext_s;
  logic signed [EXT_W-1:0] full_s;

  assign a_ext_s = EXT_W'(a);
  assign b_ext_s = EXT_W'(b);
  assign full_s  = a_ext_s + b_ext_s;

  generate
    if (SAT) begin : g_sat
      localparam logic signed [EXT_W-1:0] MAX_V = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      localparam logic signed [EXT_W-1:0] MIN_V = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

      // Clamp the exact sum into the output range.
      always_comb begin
        sum = full_s[OUT_W-1:0];
        ovf = 1'b0;
        if (full_s > MAX_V) begin
          sum = MAX_V[OUT_W-1:0];
          ovf = 1'b1;
        end else if (full_s < MIN_V) begin
          sum = MIN_V[OUT_W-1:0];
          ovf = 1'b1;
        end else begin
          sum = full_s[OUT_W-1:0];
          ovf = 1'b0;
        end
      end
    end else begin : g_wrap
      logic unused_hi_s;
      assign unused_hi_s = ^full_s;
      assign sum = full_s[OUT_W-1:0];
      assign ovf = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/mac_accum_wave_16.sv
// Group accumulator behind the 16-lane bit-serial Wave MAC with valid/ready result port.
// Define ACCUM_SAT_EN for saturating adds/narrowing and a sticky out_ovf flag.
module mac_accum_wave_16
  import wave_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [PSUM_WIDTH-1:0]   in_psum,
  input  logic                           in_first,
  input  logic                           in_last,
  input  logic                           load_accum,
  input  logic signed [ACC_WIDTH-1:0]    accum_prev,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [RESULT_WIDTH-1:0] out_result,
  output logic                           out_ovf
);

`ifdef ACCUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  acc_state_t                    state_q, state_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                          out_valid_q, out_valid_d;
  logic signed [RESULT_WIDTH-1:0] out_result_q, out_result_d;

  logic                          in_fire_s;
  logic                          start_s;
  logic signed [ACC_WIDTH-1:0]   addend_s;
  logic signed [ACC_WIDTH-1:0]   sum_s;
  logic signed [RESULT_WIDTH-1:0] narrow_s;
  logic                          ovf_acc_s;
  logic                          ovf_nar_s;

  assign in_ready  = !out_valid_q || out_ready;
  assign in_fire_s = in_valid && in_ready;
  assign start_s   = (state_q == IDLE) || in_first;

  // Start beats replace the running sum with the seed (or zero).
  always_comb begin
    if (start_s) begin
      if (load_accum) begin
        addend_s = accum_prev;
      end else begin
        addend_s = {ACC_WIDTH{1'b0}};
      end
    end else begin
      addend_s = acc_q;
    end
  end

  sat_add #(
    .A_W   (ACC_WIDTH),
    .B_W   (PSUM_WIDTH),
    .OUT_W (ACC_WIDTH),
    .SAT   (SAT)
  ) u_acc_add (
    .a   (addend_s),
    .b   (in_psum),
    .sum (sum_s),
    .ovf (ovf_acc_s)
  );

  // Adding zero turns the adder into the narrowing clamp.
  sat_add #(
    .A_W   (ACC_WIDTH),
    .B_W   (1),
    .OUT_W (RESULT_WIDTH),
    .SAT   (SAT)
  ) u_narrow (
    .a   (sum_s),
    .b   (1'sb0),
    .sum (narrow_s),
    .ovf (ovf_nar_s)
  );

  // Group sequencing and result hand-off.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    if (in_fire_s) begin
      if (in_last) begin
        state_d      = IDLE;
        acc_d        = {ACC_WIDTH{1'b0}};
        out_valid_d  = 1'b1;
        out_result_d = narrow_s;
      end else begin
        state_d = ACCUM;
        acc_d   = sum_s;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
      end
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
    end
  end

  // State and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      acc_q        <= {ACC_WIDTH{1'b0}};
      out_valid_q  <= 1'b0;
      out_result_q <= {RESULT_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;

`ifdef ACCUM_SAT_EN
  logic grp_ovf_q, grp_ovf_d;
  logic out_ovf_q, out_ovf_d;
  logic run_ovf_s;

  // Overflow is sticky within a group and cleared by its start beat.
  always_comb begin
    if (start_s) begin
      run_ovf_s = ovf_acc_s;
    end else begin
      run_ovf_s = grp_ovf_q | ovf_acc_s;
    end
    grp_ovf_d = grp_ovf_q;
    out_ovf_d = out_ovf_q;
    if (in_fire_s) begin
      if (in_last) begin
        grp_ovf_d = 1'b0;
        out_ovf_d = run_ovf_s | ovf_nar_s;
      end else begin
        grp_ovf_d = run_ovf_s;
      end
    end else begin
      grp_ovf_d = grp_ovf_q;
    end
  end

  // Overflow flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grp_ovf_q <= 1'b0;
      out_ovf_q <= 1'b0;
    end else begin
      grp_ovf_q <= grp_ovf_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign out_ovf = out_ovf_q;
`else
  logic unused_ovf_s;
  assign unused_ovf_s = ovf_acc_s | ovf_nar_s;
  assign out_ovf      = 1'b0;
`endif

endmodule

// File: tb/tb_mac_accum_wave_16.sv
// Directed bench for mac_accum_wave_16: integer-arithmetic group model checked every
// cycle, plus literal expectations for each directed scenario.
module tb_mac_accum_wave_16;

`ifdef ACCUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [18:0] in_psum;
  logic               in_first;
  logic               in_last;
  logic               load_accum;
  logic signed [23:0] accum_prev;
  logic               out_valid;
  logic               out_ready;
  logic signed [23:0] out_result;
  logic               out_ovf;

  int checks = 0;
  int failures = 0;

  mac_accum_wave_16 dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_psum    (in_psum),
    .in_first   (in_first),
    .in_last    (in_last),
    .load_accum (load_accum),
    .accum_prev (accum_prev),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_ovf    (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Fit an exact integer into 24 signed bits: clamp when saturating, else wrap.
  function automatic longint fit24(input longint v, output bit clamped);
    longint r;
    clamped = 1'b0;
    if (SAT) begin
      if (v > 64'sd8388607) begin r = 64'sd8388607; clamped = 1'b1; end
      else if (v < -64'sd8388608) begin r = -64'sd8388608; clamped = 1'b1; end
      else r = v;
    end else begin
      r = v & 64'sh0000_0000_00FF_FFFF;
      if (r >= 64'sd8388608) r = r - 64'sd16777216;
    end
    return r;
  endfunction

  // Reference model: group bookkeeping in plain integers.
  bit     m_active;
  longint m_sum;
  bit     m_ovf;
  bit     exp_valid;
  longint exp_result;
  bit     exp_ovf;

  always @(posedge clk or posedge reset) begin
    bit     fire, start, c;
    longint base, s;
    bit     grp;
    if (reset) begin
      m_active   <= 1'b0;
      m_sum      <= 64'sd0;
      m_ovf      <= 1'b0;
      exp_valid  <= 1'b0;
      exp_result <= 64'sd0;
      exp_ovf    <= 1'b0;
    end else begin
      fire = in_valid && (!exp_valid || out_ready);
      if (fire) begin
        start = !m_active || in_first;
        base  = load_accum ? longint'(accum_prev) : 64'sd0;
        s     = fit24((start ? base : m_sum) + longint'(in_psum), c);
        grp   = (start ? 1'b0 : m_ovf) | c;
        if (in_last) begin
          exp_valid  <= 1'b1;
          exp_result <= s;
          exp_ovf    <= SAT ? grp : 1'b0;
          m_active   <= 1'b0;
          m_sum      <= 64'sd0;
          m_ovf      <= 1'b0;
        end else begin
          m_active <= 1'b1;
          m_sum    <= s;
          m_ovf    <= grp;
          if (exp_valid && out_ready) exp_valid <= 1'b0;
        end
      end else if (exp_valid && out_ready) begin
        exp_valid <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      chk("in_ready", in_ready, (!exp_valid || out_ready));
      chk("out_valid", out_valid, exp_valid);
      if (exp_valid) begin
        chk("out_result", out_result, exp_result);
        chk("out_ovf", out_ovf, exp_ovf);
      end
    end
  end

  task automatic send(input longint psum, input bit first, input bit last,
                      input bit load, input longint prev);
    int n;
    in_psum    = 19'(psum);
    in_first   = first;
    in_last    = last;
    load_accum = load;
    accum_prev = 24'(prev);
    in_valid   = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
    end
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_first   = 1'b0;
    in_last    = 1'b0;
    load_accum = 1'b0;
    in_psum    = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_psum = '0; in_first = 1'b0; in_last = 1'b0;
    load_accum = 1'b0; accum_prev = '0; out_ready = 1'b1;
    idle(3);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    // 1: 100 - 30 + 64
    send(100, 1, 0, 0, 0);
    send(-30, 0, 0, 0, 0);
    send(64, 0, 1, 0, 0);
    chk("t1_valid", out_valid, 1);
    chk("t1_result", out_result, 134);
    idle(2);

    // 2: single beat seeded with -1000
    send(200, 1, 1, 1, -1000);
    chk("t2_result", out_result, -800);
    idle(2);

    // 3: back-pressure, then accept a new group in the draining cycle
    out_ready = 1'b0;
    send(42, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_in_ready_low", in_ready, 0);
      chk("t3_result_stable", out_result, 42);
    end
    #1;
    out_ready = 1'b1;
    send(7, 1, 1, 0, 0);
    chk("t3_valid_kept", out_valid, 1);
    chk("t3_result_new", out_result, 7);
    idle(2);

    // 4: restart discards 50+20; load_accum on a middle beat is ignored
    send(50, 1, 0, 0, 0);
    send(20, 0, 0, 1, 999);
    send(7, 1, 0, 0, 0);
    send(3, 0, 1, 0, 0);
    chk("t4_result", out_result, 10);
    idle(2);

    // 5: (2^23-10)+100 = 2^23+90 overflows
    send(100, 1, 1, 1, 8388598);
    chk("t5_result", out_result, SAT ? 8388607 : -8388518);
    chk("t5_ovf", out_ovf, SAT ? 1 : 0);
    idle(2);

    // 6: reset mid-group
    send(1, 1, 0, 0, 0);
    send(2, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_result", out_result, 0);
    chk("t6_rst_ovf", out_ovf, 0);
    chk("t6_rst_in_ready", in_ready, 1);
    @(negedge clk);
    #1;
    reset = 1'b0;
    idle(1);
    send(5, 1, 0, 0, 0);
    send(5, 0, 1, 0, 0);
    chk("t6_result", out_result, 10);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
